// File: rtl/eth_mac_tx_arb.sv
// eth_mac_tx_arb: packet-level round-robin arbiter that merges PORTS
// AXI-stream byte requesters onto a single MAC TX stream.
// A grant is held for a whole packet and released on the accepted tlast beat.
// One idle cycle always separates consecutive packets.
// Optional feature: define ETH_TX_ARB_STATS_EN to build per-port saturating
// completed-packet counters; otherwise stat_pkt_count is tied to zero.
//
// state | meaning
// IDLE  | no port owns the MAC stream; arbitrate when cfg_enable is high
// XFER  | granted port streams to the MAC until its tlast beat is accepted
module eth_mac_tx_arb #(
    parameter int PORTS           = 4,
    parameter int LAST_GRANT_INIT = PORTS - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PORTS*8-1:0]  s_axis_tdata,
    input  logic [PORTS-1:0]    s_axis_tvalid,
    output logic [PORTS-1:0]    s_axis_tready,
    input  logic [PORTS-1:0]    s_axis_tlast,
    input  logic [PORTS-1:0]    s_axis_tuser,
    output logic [7:0]          m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                m_axis_tuser,
    input  logic                cfg_enable,
    output logic                grant_valid,
    output logic [2:0]          grant_index,
    output logic [PORTS*16-1:0] stat_pkt_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] grant_idx_q, grant_idx_d;
    logic [2:0] last_grant_q, last_grant_d;
    logic       grant_valid_q, grant_valid_d;

    logic       pick_found;
    logic [2:0] pick_idx;
    logic       beat_last;

    // Round-robin search: first valid port starting just above the last grant.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= PORTS; i++) begin
            // last_grant < PORTS and i <= PORTS, so one subtraction wraps it.
            cand = int'(last_grant_q) + i;
            if (cand >= PORTS) begin
                cand = cand - PORTS;
            end
            for (int j = 0; j < PORTS; j++) begin
                if (!pick_found && (cand == j) && s_axis_tvalid[j]) begin
                    pick_found = 1'b1;
                    pick_idx   = 3'(j);
                end
            end
        end
    end

    // Steer the granted port to the MAC; everything is quiet outside XFER.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        if (state_q == XFER) begin
            for (int j = 0; j < PORTS; j++) begin
                if (grant_idx_q == 3'(j)) begin
                    m_axis_tdata     = s_axis_tdata[j*8 +: 8];
                    m_axis_tvalid    = s_axis_tvalid[j];
                    m_axis_tlast     = s_axis_tlast[j];
                    m_axis_tuser     = s_axis_tuser[j];
                    s_axis_tready[j] = m_axis_tready;
                end
            end
        end
    end

    // An accepted end-of-frame beat closes the current packet.
    assign beat_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Next-state logic: grant whole packets, release only on the tlast beat.
    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        last_grant_d  = last_grant_q;
        grant_valid_d = grant_valid_q;
        case (state_q)
            IDLE: begin
                if (cfg_enable && pick_found) begin
                    state_d       = XFER;
                    grant_idx_d   = pick_idx;
                    last_grant_d  = pick_idx;
                    grant_valid_d = 1'b1;
                end
            end
            XFER: begin
                // cfg_enable is deliberately ignored here: a packet is never cut.
                if (beat_last) begin
                    state_d       = IDLE;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_idx_d   = '0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // FSM and registered grant outputs; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_idx_q   <= '0;
            last_grant_q  <= 3'(LAST_GRANT_INIT);
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            last_grant_q  <= last_grant_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_index = grant_idx_q;

`ifdef ETH_TX_ARB_STATS_EN
    logic [15:0] stat_cnt_q [PORTS];
    logic [15:0] stat_cnt_d [PORTS];

    // Count completed packets per port, tuser-marked ones included; hold at max.
    always_comb begin
        for (int j = 0; j < PORTS; j++) begin
            stat_cnt_d[j] = stat_cnt_q[j];
            if (beat_last && (grant_idx_q == 3'(j)) && (stat_cnt_q[j] != 16'hFFFF)) begin
                stat_cnt_d[j] = stat_cnt_q[j] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < PORTS; j++) begin
                stat_cnt_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < PORTS; j++) begin
                stat_cnt_q[j] <= stat_cnt_d[j];
            end
        end
    end

    // Flatten counters onto the status bus, port i at [16i+15:16i].
    always_comb begin
        stat_pkt_count = '0;
        for (int j = 0; j < PORTS; j++) begin
            stat_pkt_count[j*16 +: 16] = stat_cnt_q[j];
        end
    end
`else
    assign stat_pkt_count = '0;
`endif

endmodule

// File: tb/tb_eth_mac_tx_arb.sv
// Bench for eth_mac_tx_arb (PORTS=4): cycle vectors plus hand sequences for
// backpressure, reset mid-packet and packet statistics.
module tb_eth_mac_tx_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tvalid;
    logic [3:0]  s_axis_tready;
    logic [3:0]  s_axis_tlast;
    logic [3:0]  s_axis_tuser;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        cfg_enable;
    logic        grant_valid;
    logic [2:0]  grant_index;
    logic [63:0] stat_pkt_count;

    int total = 0;
    int bad   = 0;

    eth_mac_tx_arb #(.PORTS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .cfg_enable     (cfg_enable),
        .grant_valid    (grant_valid),
        .grant_index    (grant_index),
        .stat_pkt_count (stat_pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [3:0]  usr;
        logic        mrdy;
        logic        en;
        logic [31:0] data;
        logic        gv;
        logic [2:0]  gi;
        logic        mv;
        logic [7:0]  md;
        logic        ml;
        logic        mu;
        logic [3:0]  srdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] vld, input logic [3:0] lst,
                       input logic [3:0] usr, input logic mrdy, input logic en,
                       input logic [31:0] data, input logic gv, input logic [2:0] gi,
                       input logic mv, input logic [7:0] md, input logic ml,
                       input logic mu, input logic [3:0] srdy);
        vec_t v;
        v.rst = r; v.vld = vld; v.lst = lst; v.usr = usr; v.mrdy = mrdy; v.en = en;
        v.data = data; v.gv = gv; v.gi = gi; v.mv = mv; v.md = md; v.ml = ml;
        v.mu = mu; v.srdy = srdy;
        vecs.push_back(v);
    endtask

    task automatic idle_row(input logic r, input logic [3:0] vld, input logic [3:0] lst,
                            input logic en, input logic [31:0] data);
        add(r, vld, lst, 4'h0, 1'b1, en, data, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    endtask

    // Leaves the bench at posedge+1 with reset released and inputs idle.
    task automatic do_reset();
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        cfg_enable    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] D2 = 32'hB3B2B1B0;

    initial begin
        logic [7:0]  got_d [6];
        logic [2:0]  got_g [6];
        int          nbeats;
        int          p1_k;
        logic        p3_done;
        int          npk;
        logic        found;
        logic [63:0] exp_stat;

        // ---- reset state
        do_reset();
        rst = 1'b1;
        s_axis_tvalid = 4'hF;
        s_axis_tlast  = 4'hF;
        s_axis_tdata  = D2;
        #2;
        chk("rst_outputs", {grant_valid, grant_index, m_axis_tvalid, m_axis_tdata,
                            m_axis_tlast, m_axis_tuser, s_axis_tready},
            64'h0);
        chk("rst_stats", stat_pkt_count, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;

        // ---- vector table
        // all ports valid, single-beat packets: 0,1,2,3,0 one beat per 2 cycles
        idle_row(0, 4'hF, 4'hF, 1, D2);
        add(0, 4'hF, 4'hF, 4'h0, 1, 1, D2, 1, 3'd0, 1, 8'hB0, 1, 0, 4'h1);
        idle_row(0, 4'hF, 4'hF, 1, D2);
        add(0, 4'hF, 4'hF, 4'h0, 1, 1, D2, 1, 3'd1, 1, 8'hB1, 1, 0, 4'h2);
        idle_row(0, 4'hF, 4'hF, 1, D2);
        add(0, 4'hF, 4'hF, 4'h0, 1, 1, D2, 1, 3'd2, 1, 8'hB2, 1, 0, 4'h4);
        idle_row(0, 4'hF, 4'hF, 1, D2);
        add(0, 4'hF, 4'hF, 4'h0, 1, 1, D2, 1, 3'd3, 1, 8'hB3, 1, 0, 4'h8);
        idle_row(0, 4'hF, 4'hF, 1, D2);
        add(0, 4'hF, 4'hF, 4'h0, 1, 1, D2, 1, 3'd0, 1, 8'hB0, 1, 0, 4'h1);
        idle_row(0, 4'h0, 4'h0, 1, 32'h0);
        // reset restores the pointer; outputs stay quiet with valids high
        idle_row(1, 4'hF, 4'hF, 1, D2);
        // ports 0 and 2, 3-beat packets: beats at cycles 1-3 and 5-7
        idle_row(0, 4'h5, 4'h0, 1, 32'h00210001);
        add(0, 4'h5, 4'h0, 4'h0, 1, 1, 32'h00210001, 1, 3'd0, 1, 8'h01, 0, 0, 4'h1);
        add(0, 4'h5, 4'h0, 4'h0, 1, 1, 32'h00210002, 1, 3'd0, 1, 8'h02, 0, 0, 4'h1);
        add(0, 4'h5, 4'h1, 4'h0, 1, 1, 32'h00210003, 1, 3'd0, 1, 8'h03, 1, 0, 4'h1);
        idle_row(0, 4'h4, 4'h0, 1, 32'h00210000);
        add(0, 4'h4, 4'h0, 4'h0, 1, 1, 32'h00210000, 1, 3'd2, 1, 8'h21, 0, 0, 4'h4);
        add(0, 4'h4, 4'h0, 4'h0, 1, 1, 32'h00220000, 1, 3'd2, 1, 8'h22, 0, 0, 4'h4);
        add(0, 4'h4, 4'h4, 4'h4, 1, 1, 32'h00230000, 1, 3'd2, 1, 8'h23, 1, 1, 4'h4);
        idle_row(0, 4'h0, 4'h0, 1, 32'h0);
        // cfg_enable drops on beat 2 of a 4-beat packet from port 1
        idle_row(0, 4'h2, 4'h0, 1, 32'h00004100);
        add(0, 4'h2, 4'h0, 4'h0, 1, 1, 32'h00004100, 1, 3'd1, 1, 8'h41, 0, 0, 4'h2);
        add(0, 4'h2, 4'h0, 4'h0, 1, 0, 32'h00004200, 1, 3'd1, 1, 8'h42, 0, 0, 4'h2);
        add(0, 4'h2, 4'h0, 4'h0, 1, 0, 32'h00004300, 1, 3'd1, 1, 8'h43, 0, 0, 4'h2);
        add(0, 4'h2, 4'h2, 4'h0, 1, 0, 32'h00004400, 1, 3'd1, 1, 8'h44, 1, 0, 4'h2);
        idle_row(0, 4'hF, 4'h0, 0, D2);
        idle_row(0, 4'hF, 4'h0, 0, D2);
        idle_row(0, 4'hF, 4'h0, 0, D2);
        // re-enable: search resumes after port 1
        idle_row(0, 4'hF, 4'hF, 1, D2);
        add(0, 4'hF, 4'hF, 4'h0, 1, 1, D2, 1, 3'd2, 1, 8'hB2, 1, 0, 4'h4);
        idle_row(0, 4'h0, 4'h0, 1, 32'h0);

        foreach (vecs[r]) begin
            rst           = vecs[r].rst;
            s_axis_tvalid = vecs[r].vld;
            s_axis_tlast  = vecs[r].lst;
            s_axis_tuser  = vecs[r].usr;
            m_axis_tready = vecs[r].mrdy;
            cfg_enable    = vecs[r].en;
            s_axis_tdata  = vecs[r].data;
            @(negedge clk);
            chk($sformatf("vec%0d", r),
                {grant_valid, grant_index, m_axis_tvalid, m_axis_tdata,
                 m_axis_tlast, m_axis_tuser, s_axis_tready},
                {vecs[r].gv, vecs[r].gi, vecs[r].mv, vecs[r].md,
                 vecs[r].ml, vecs[r].mu, vecs[r].srdy});
            @(posedge clk);
            #1;
        end

        // ---- backpressure: 5-beat packet from port 1, port 3 waiting
        do_reset();
        nbeats  = 0;
        p1_k    = 0;
        p3_done = 1'b0;
        for (int cyc = 0; cyc < 60 && nbeats < 6; cyc++) begin
            m_axis_tready = (cyc % 2 == 0);
            s_axis_tdata  = {8'h7F, 8'h00, 8'(8'h50 + p1_k), 8'h00};
            s_axis_tvalid = {~p3_done, 1'b0, (p1_k < 5), 1'b0};
            s_axis_tlast  = {1'b1, 1'b0, (p1_k == 4), 1'b0};
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) begin
                if (nbeats < 6) begin
                    got_d[nbeats] = m_axis_tdata;
                    got_g[nbeats] = grant_index;
                end
                nbeats++;
            end
            if (s_axis_tready[1] && s_axis_tvalid[1]) p1_k++;
            if (s_axis_tready[3] && s_axis_tvalid[3]) p3_done = 1'b1;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = '0;
        chk("bp_beat_count", nbeats, 6);
        for (int k = 0; k < 6 && k < nbeats; k++) begin
            chk($sformatf("bp_beat%0d", k), {got_g[k], got_d[k]},
                (k < 5) ? {3'd1, 8'(8'h50 + k)} : {3'd3, 8'h7F});
        end

        // ---- reset on the 2nd beat of a packet from port 2
        do_reset();
        s_axis_tvalid = 4'h4;
        s_axis_tdata  = 32'h00600000;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstmid_first_beat", {grant_valid, grant_index, m_axis_tvalid, m_axis_tdata},
            {1'b1, 3'd2, 1'b1, 8'h60});
        @(posedge clk);
        #1;
        s_axis_tdata = 32'h00610000;
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_outputs", {grant_valid, grant_index, m_axis_tvalid, m_axis_tdata,
                               m_axis_tlast, m_axis_tuser, s_axis_tready},
            64'h0);
        @(negedge clk);
        rst           = 1'b0;
        s_axis_tvalid = 4'hF;
        s_axis_tlast  = 4'hF;
        s_axis_tdata  = D2;
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            if (grant_valid) found = 1'b1;
        end
        chk("rstmid_regrant_seen", found, 1'b1);
        chk("rstmid_regrant_port", grant_index, 3'd0);
        @(posedge clk);
        #1;
        s_axis_tvalid = '0;

        // ---- statistics: 3 single-beat packets from port 1, middle one bad
        do_reset();
        chk("stats_after_reset", stat_pkt_count, 64'h0);
        npk = 0;
        for (int cyc = 0; cyc < 30 && npk < 3; cyc++) begin
            s_axis_tvalid = 4'h2;
            s_axis_tlast  = 4'h2;
            s_axis_tuser  = {2'b00, (npk == 1), 1'b0};
            s_axis_tdata  = {16'h0, 8'(8'h90 + npk), 8'h00};
            @(negedge clk);
            if (s_axis_tready[1]) begin
                chk($sformatf("stats_pkt%0d", npk), {m_axis_tdata, m_axis_tuser},
                    {8'(8'h90 + npk), (npk == 1)});
                npk++;
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        chk("stats_pkts_sent", npk, 3);
        repeat (2) @(posedge clk);
        #1;
`ifdef ETH_TX_ARB_STATS_EN
        exp_stat = {16'd0, 16'd0, 16'd3, 16'd0};
`else
        exp_stat = 64'h0;
`endif
        chk("stats_counts", stat_pkt_count, exp_stat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_mac_tx_arb.md
ETH_MAC_TX_ARB -- requirements
Module: eth_mac_tx_arb

Interface
REQ-001 Parameter PORTS, default 4: number of AXI-stream requesters; legal range 2..8.
REQ-002 Parameter LAST_GRANT_INIT, default PORTS-1: round-robin pointer value after reset.
REQ-003 clk  input  1: single clock for all logic.
REQ-004 rst  input  1: reset; asynchronous, active-high.
REQ-005 s_axis_tdata  input  PORTS*8: requester data; port i occupies bits [8i+7:8i].
REQ-006 s_axis_tvalid  input  PORTS: per-port valid.
REQ-007 s_axis_tready  output  PORTS: per-port ready.
REQ-008 s_axis_tlast  input  PORTS: per-port end of frame.
REQ-009 s_axis_tuser  input  PORTS: per-port bad-frame marker, meaningful on the tlast beat.
REQ-010 m_axis_tdata  output  8: data to the MAC TX stream.
REQ-011 m_axis_tvalid  output  1: MAC stream valid.
REQ-012 m_axis_tready  input  1: MAC stream ready.
REQ-013 m_axis_tlast  output  1: MAC stream end of frame.
REQ-014 m_axis_tuser  output  1: MAC stream bad-frame marker.
REQ-015 cfg_enable  input  1: 1 = new grants allowed; 0 = no new grants.
REQ-016 grant_valid  output  1: a packet transfer is in progress.
REQ-017 grant_index  output  3: index of the granted port; 0 when grant_valid=0.
REQ-018 stat_pkt_count  output  PORTS*16: per-port completed-packet counters (see Configuration).

Function
REQ-019 FSM has two states, IDLE and XFER; reset state is IDLE.
REQ-020 IDLE with cfg_enable=1 and any s_axis_tvalid high: on the next edge, grant the first asserted port searching upward from (last_grant+1) mod PORTS, store it in grant_index, set last_grant to it, and enter XFER.
REQ-021 IDLE: m_axis_tvalid=0 and all s_axis_tready=0.
REQ-022 XFER: m_axis_tdata/tvalid/tlast/tuser equal the granted port's inputs combinationally; s_axis_tready[grant]=m_axis_tready; all other tready=0.
REQ-023 XFER: a beat with m_axis_tvalid, m_axis_tready and m_axis_tlast all high returns the FSM to IDLE on that edge; grant_valid falls on the same edge.
REQ-024 Arbitration is per packet; a grant is never revoked mid-packet, regardless of cfg_enable or other tvalids.
REQ-025 Fixed one-cycle bubble between packets: the minimum spacing from the tlast beat to the next packet's first beat is 2 cycles.
REQ-026 cfg_enable=0 during XFER: the current packet completes; no new grant is issued afterwards.
REQ-027 A single-beat packet (first beat carries tlast) is legal and completes in one XFER cycle.
REQ-028 Port count arithmetic is modulo PORTS; the pointer wraps from PORTS-1 to 0.
REQ-029 The block does not alter data, reorder beats, or inspect tuser other than for statistics.

Reset
REQ-030 Asserting rst at any time, including mid-packet, forces IDLE, grant_valid=0, grant_index=0, last_grant=LAST_GRANT_INIT, and all counters to 0.
REQ-031 While rst is high: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, and s_axis_tready=0.
REQ-032 A packet truncated by reset is not resumed; downstream recovery is the MAC's responsibility.

Configuration
REQ-033 Macro ETH_TX_ARB_STATS_EN defined: each port has a 16-bit counter that increments on every completed tlast beat from that port and saturates at 0xFFFF.
REQ-034 Macro ETH_TX_ARB_STATS_EN undefined: no counters are built and stat_pkt_count is tied to 0; the port list is unchanged.

Verification
REQ-035 Scenario: PORTS=4; ports 0 and 2 each present one 3-beat packet; m_axis_tready=1 -> port 0 is sent first, then port 2; m_axis beats at cycles 1-3 and 5-7 after the first valid.
REQ-036 Scenario: all 4 ports continuously valid with 1-beat packets -> grant order 0,1,2,3,0,...; one beat every 2 cycles.
REQ-037 Scenario: m_axis_tready toggles 1/0 during a 5-beat packet from port 1 while port 3 is valid -> all 5 beats from port 1 are in order with no port 3 interleave; port 3 is granted only after tlast.
REQ-038 Scenario: cfg_enable drops to 0 on the 2nd beat of a 4-beat packet -> all 4 beats complete; FSM stays in IDLE while tvalids remain high.
REQ-039 Scenario: rst is pulsed on the 2nd beat of a packet from port 2 -> m_axis_tvalid=0 within the same cycle; the next grant after reset goes to port 0.
REQ-040 Scenario: with ETH_TX_ARB_STATS_EN, send 3 packets from port 1 (one with tuser=1) -> stat_pkt_count for port 1 equals 3 and the other ports stay 0; without the macro, all counters read 0.
